// File: rtl/sw_debounce.sv
// sw_debounce: per-bit synchroniser plus stability counter for raw board switches.
// A bit of sw follows its synchronised input only after the two have disagreed for
// DEBOUNCE_TICKS consecutive cycles; rise/fall/sw_changed pulse on the committing edge.
module sw_debounce #(
  parameter int WIDTH          = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             sw_changed
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] sw_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  // Synchroniser chain: every stage is cleared on reset so the first
  // post-reset samples read as the stable value 0.
  // NOTE: this array is a handful of flops, not a RAM, so resetting every
  // entry is cheap and keeps the reset state fully defined.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, which is what turns this loop into a shift register.
      sync_q[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Per-bit next-state logic: settle counting, bounce rejection and commit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below can leave a value unassigned and infer a latch.
    sw_d   = sw;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end

    for (int i = 0; i < WIDTH; i++) begin
      unique case (state_q[i])
        STABLE: begin
          if (sync[i] != sw[i]) begin
            if (DEBOUNCE_TICKS == 1) begin
              sw_d[i]    = sync[i];
              rise_d[i]  = sync[i];
              fall_d[i]  = ~sync[i];
              cnt_d[i]   = '0;
              state_d[i] = STABLE;
            end else begin
              cnt_d[i]   = CNT_ONE;
              state_d[i] = SETTLING;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
        SETTLING: begin
          if (sync[i] == sw[i]) begin
            // Input bounced back before qualifying: drop the attempt silently.
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            sw_d[i]    = sync[i];
            rise_d[i]  = sync[i];
            fall_d[i]  = ~sync[i];
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = STABLE;
        end
      endcase
    end
  end

  // State, counter and registered outputs; strobes coincide with the sw update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      sw         <= '0;
      rise       <= '0;
      fall       <= '0;
      sw_changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw         <= sw_d;
      rise       <= rise_d;
      fall       <= fall_d;
      sw_changed <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce: directed scenarios plus randomized switch activity,
// checked every cycle against a window-based reference model.
module tb_sw_debounce;

  localparam int W    = 3;
  localparam int SYNC = 2;
  localparam int T    = 8;

  typedef logic [W-1:0] vec_t;

  logic   clk = 1'b0;
  logic   rst_n;
  vec_t   sw_raw;
  vec_t   sw;
  vec_t   rise;
  vec_t   fall;
  logic   sw_changed;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  vec_t raw_hist [$];   // sw_raw sampled at each non-reset edge (with SYNC zeros after reset)
  vec_t in_hist  [$];   // value the debouncer sees at each edge since reset
  vec_t sw_m, rise_m, fall_m;
  logic chg_m;

  sw_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_TICKS (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw         (sw),
    .rise       (rise),
    .fall       (fall),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a bit flips when the last T values the debouncer saw since reset
  // all differ from its current output; the input is raw delayed SYNC edges.
  task automatic model_edge();
    vec_t in_v;
    bit   all_diff;
    rise_m = '0;
    fall_m = '0;
    if (!rst_n) begin
      raw_hist = {};
      for (int k = 0; k < SYNC; k++) raw_hist.push_back('0);
      in_hist = {};
      sw_m    = '0;
    end else begin
      in_v = raw_hist[raw_hist.size() - SYNC];
      raw_hist.push_back(sw_raw);
      in_hist.push_back(in_v);
      if (raw_hist.size() > 64) void'(raw_hist.pop_front());
      if (in_hist.size() > 64) void'(in_hist.pop_front());
      for (int i = 0; i < W; i++) begin
        if (in_hist.size() >= T) begin
          all_diff = 1'b1;
          for (int j = 0; j < T; j++)
            if (in_hist[in_hist.size() - 1 - j][i] == sw_m[i]) all_diff = 1'b0;
          if (all_diff) begin
            sw_m[i]   = ~sw_m[i];
            rise_m[i] = sw_m[i];
            fall_m[i] = ~sw_m[i];
          end
        end
      end
    end
    chg_m = |(rise_m | fall_m);
  endtask

  // One clock: update model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("sw",   sw,         sw_m);
    check("rise", rise,       rise_m);
    check("fall", fall,       fall_m);
    check("chg",  sw_changed, chg_m);
  endtask

  task automatic settle(input vec_t v);
    sw_raw = v;
    repeat (T + SYNC + 2) step();
  endtask

  int rises;
  int hold;

  initial begin
    rst_n  = 1'b0;
    sw_raw = 3'b101;

    // 1: raw held through reset, then qualifies with full latency.
    repeat (2) begin
      step();
      check("s1_rst_sw", sw, 3'b000);
      check("s1_rst_strobes", {rise, fall, sw_changed}, 7'd0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      if (e == 9)  check("s1_e9_sw", sw, 3'b000);
      if (e == 10) begin
        check("s1_e10_sw", sw, 3'b101);
        check("s1_e10_rise", rise, 3'b101);
        check("s1_e10_chg", sw_changed, 1'b1);
      end
      if (e == 11) check("s1_e11_chg", sw_changed, 1'b0);
    end
    settle(3'b000);

    // 2: clean step on bit 1.
    sw_raw = 3'b010;
    for (int e = 1; e <= 12; e++) begin
      step();
      check("s2_fall", fall, 3'b000);
      if (e == 9)  check("s2_e9_sw1", sw[1], 1'b0);
      if (e == 10) begin
        check("s2_e10_sw1", sw[1], 1'b1);
        check("s2_e10_rise1", rise[1], 1'b1);
      end
      if (e == 11) check("s2_e11_rise1", rise[1], 1'b0);
    end
    settle(3'b000);

    // 3: 7-cycle glitches on bit 0 are rejected.
    for (int g = 0; g < 4; g++) begin
      sw_raw = 3'b001;
      repeat (7) begin step(); check("s3_sw0", sw[0], 1'b0); check("s3_rise0", rise[0], 1'b0); end
      sw_raw = 3'b000;
      repeat (3) begin step(); check("s3_sw0", sw[0], 1'b0); check("s3_rise0", rise[0], 1'b0); end
    end
    settle(3'b000);

    // 4: bounce every 3 cycles, then hold high.
    for (int b = 0; b < 10; b++) begin
      sw_raw = (b % 2 == 0) ? 3'b001 : 3'b000;
      repeat (3) begin step(); check("s4_bounce_sw0", sw[0], 1'b0); end
    end
    sw_raw = 3'b001;
    rises  = 0;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (rise[0]) rises++;
      if (e == 9)  check("s4_e9_sw0", sw[0], 1'b0);
      if (e == 10) check("s4_e10_sw0", sw[0], 1'b1);
    end
    check("s4_rise_count", rises, 1);

    // 5: simultaneous fall on bit 0 and rise on bit 2.
    sw_raw = 3'b100;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 10) begin
        check("s5_sw", sw, 3'b100);
        check("s5_rise", rise, 3'b100);
        check("s5_fall", fall, 3'b001);
        check("s5_chg", sw_changed, 1'b1);
      end
      if (e == 11) check("s5_chg_off", sw_changed, 1'b0);
    end
    settle(3'b000);

    // 6: reset mid-settle on bit 2 restarts the full qualification.
    sw_raw = 3'b100;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    check("s6_rst_sw", sw, 3'b000);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 9)  check("s6_e9_sw2", sw[2], 1'b0);
      if (e == 10) begin
        check("s6_e10_sw2", sw[2], 1'b1);
        check("s6_e10_rise2", rise[2], 1'b1);
      end
    end

    // Random switch activity with occasional resets.
    for (int r = 0; r < 120; r++) begin
      sw_raw = vec_t'($urandom_range(0, 7));
      hold   = $urandom_range(1, 14);
      repeat (hold) begin
        rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
        step();
      end
    end
    rst_n = 1'b1;
    settle(3'b011);
    check("final_sw", sw, 3'b011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
